// File: rtl/regfile_np_bypass.sv
// Multi-port register file with same-cycle write forwarding and a pending-write scoreboard.
// Latency: reads are combinational (zero cycles); writes and scoreboard updates land on the rising clk edge.
// Backpressure: none; rd_busy tells hazard logic to stall when a register still awaits a long-latency result.
module regfile_np_bypass #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic [NREAD*ADDR_W-1:0]   rd_addr,
  output logic [NREAD*DATA_W-1:0]   rd_data,
  input  logic                      sb_set,
  input  logic [ADDR_W-1:0]         sb_addr,
  output logic [NREAD-1:0]          rd_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;

  // Writes and sets aimed at the hardwired zero register are discarded up front,
  // so neither storage, scoreboard nor forwarding ever sees them.
  logic wr_eff;
  logic sb_eff;

  assign wr_eff = wr_en  && !((ZERO_REG != 0) && (wr_addr == '0));
  assign sb_eff = sb_set && !((ZERO_REG != 0) && (sb_addr == '0));

  // Register storage: cleared asynchronously, one write per edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_eff) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Scoreboard next state: a retiring write clears, a newly issued load sets; set is
  // applied last so it wins when both name the same register.
  always_comb begin
    busy_nxt = busy;
    if (wr_eff) begin
      busy_nxt[wr_addr] = 1'b0;
    end
    if (sb_eff) begin
      busy_nxt[sb_addr] = 1'b1;
    end
  end

  // Scoreboard state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Independent read ports. Forwarding is suppressed during reset so the outputs
  // read zero for as long as reset is held, whatever the write inputs do.
  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              is_zero;
    logic              hit_wr;
    logic              hit_sb;

    assign ra      = rd_addr[p*ADDR_W +: ADDR_W];
    assign is_zero = (ZERO_REG != 0) && (ra == '0);
    assign hit_wr  = (BYPASS != 0) && !reset && wr_eff && (wr_addr == ra);
    assign hit_sb  = sb_eff && (sb_addr == ra);

    assign rd_data[p*DATA_W +: DATA_W] = is_zero ? '0 :
                                         hit_wr  ? wr_data : mem[ra];

    // A forwarded write retires the pending result, unless a new load to the same
    // register issues on the same edge and keeps it pending.
    assign rd_busy[p] = is_zero              ? 1'b0 :
                        (hit_wr && !hit_sb)  ? 1'b0 : busy[ra];
  end

endmodule

// File: tb/tb_regfile_np_bypass.sv
// Bench for regfile_np_bypass: directed vector table on the default configuration,
// reset corner sequences, and a randomised run of a 4-port/64-bit/16-entry build
// against a reference model. Expected values flow through a scoreboard queue.
module tb_regfile_np_bypass;

  // default configuration (instance a)
  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic        sb_set;
  logic [4:0]  sb_addr;
  logic [1:0]  rd_busy;

  // wide configuration (instance b)
  logic         b_wr_en;
  logic [3:0]   b_wr_addr;
  logic [63:0]  b_wr_data;
  logic [15:0]  b_rd_addr;
  logic [255:0] b_rd_data;
  logic         b_sb_set;
  logic [3:0]   b_sb_addr;
  logic [3:0]   b_rd_busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] data;
    logic        busy;
  } exp_t;
  exp_t sbq[$];

  typedef struct packed {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ss;
    logic [4:0]  sa;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        b0;
    logic        b1;
  } vec_t;
  vec_t tbl [15];

  always #5 clk = ~clk;

  regfile_np_bypass #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .sb_set(sb_set), .sb_addr(sb_addr), .rd_busy(rd_busy)
  );

  regfile_np_bypass #(.DATA_W(64), .ADDR_W(4), .NREAD(4), .ZERO_REG(1), .BYPASS(1)) dut_b (
    .clk(clk), .reset(reset), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data), .sb_set(b_sb_set), .sb_addr(b_sb_addr), .rd_busy(b_rd_busy)
  );

  task automatic expect_push(input logic [63:0] d, input logic b);
    exp_t e;
    e.data = d;
    e.busy = b;
    sbq.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] act_d, input logic act_b);
    exp_t e;
    checks++;
    if (sbq.size() == 0) begin
      failures++;
      $display("FAIL %s: no expected entry queued (got data=%h busy=%b)", name, act_d, act_b);
    end else begin
      e = sbq.pop_front();
      if (act_d !== e.data || act_b !== e.busy) begin
        failures++;
        $display("FAIL %s: got data=%h busy=%b, expected data=%h busy=%b",
                 name, act_d, act_b, e.data, e.busy);
      end
    end
  endtask

  task automatic idle_a();
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    sb_set  = 1'b0;
    sb_addr = '0;
  endtask

  // Read every address on both ports (port1 walks downward); all must be zero/idle.
  task automatic sweep_zero(input string tag);
    for (int a = 0; a < 32; a++) begin
      idle_a();
      rd_addr = {5'(31 - a), 5'(a)};
      expect_push(64'h0, 1'b0);
      expect_push(64'h0, 1'b0);
      @(negedge clk);
      chk($sformatf("%s.p0.r%0d", tag, a), {32'h0, rd_data[31:0]}, rd_busy[0]);
      chk($sformatf("%s.p1.r%0d", tag, 31 - a), {32'h0, rd_data[63:32]}, rd_busy[1]);
      @(posedge clk);
      #1;
    end
  endtask

  // reference model for instance b
  logic [63:0] m2    [16];
  logic        busy2 [16];

  initial begin
    // fields: we wa wd ss sa ra0 ra1 d0 d1 b0 b1
    tbl[0]  = {1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd31, 32'h0,        32'h0,        1'b0, 1'b0};
    tbl[1]  = {1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
    tbl[2]  = {1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
    tbl[3]  = {1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 5'd0, 5'd0,  32'h0,        32'h0,        1'b0, 1'b0};
    tbl[4]  = {1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd5,  32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
    tbl[5]  = {1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd7, 5'd7,  32'h0,        32'h0,        1'b0, 1'b0};
    tbl[6]  = {1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd5,  32'h0,        32'hDEADBEEF, 1'b1, 1'b0};
    tbl[7]  = {1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd7, 5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 1'b0};
    tbl[8]  = {1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 1'b0};
    tbl[9]  = {1'b1, 5'd7, 32'h11111111, 1'b1, 5'd7, 5'd7, 5'd7,  32'h11111111, 32'h11111111, 1'b0, 1'b0};
    tbl[10] = {1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd7,  32'h11111111, 32'h11111111, 1'b1, 1'b1};
    tbl[11] = {1'b1, 5'd7, 32'h22222222, 1'b1, 5'd7, 5'd7, 5'd6,  32'h22222222, 32'h0,        1'b1, 1'b0};
    tbl[12] = {1'b1, 5'd7, 32'h33333333, 1'b1, 5'd9, 5'd7, 5'd9,  32'h33333333, 32'h0,        1'b0, 1'b0};
    tbl[13] = {1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd9,  32'h33333333, 32'h0,        1'b0, 1'b1};
    tbl[14] = {1'b1, 5'd9, 32'h44444444, 1'b0, 5'd0, 5'd9, 5'd9,  32'h44444444, 32'h44444444, 1'b0, 1'b0};

    for (int i = 0; i < 16; i++) begin
      m2[i]    = '0;
      busy2[i] = 1'b0;
    end
    b_wr_en   = 1'b0;
    b_wr_addr = '0;
    b_wr_data = '0;
    b_rd_addr = '0;
    b_sb_set  = 1'b0;
    b_sb_addr = '0;

    // Reset held: a write presented now must neither forward nor persist.
    reset   = 1'b1;
    idle_a();
    rd_addr = '0;
    #2;
    wr_en   = 1'b1;
    wr_addr = 5'd5;
    wr_data = 32'hDEADBEEF;
    sb_set  = 1'b1;
    sb_addr = 5'd5;
    rd_addr = {5'd5, 5'd5};
    expect_push(64'h0, 1'b0);
    expect_push(64'h0, 1'b0);
    #1;
    chk("in_reset.p0", {32'h0, rd_data[31:0]}, rd_busy[0]);
    chk("in_reset.p1", {32'h0, rd_data[63:32]}, rd_busy[1]);
    @(posedge clk);
    @(posedge clk);
    #1;
    idle_a();
    #1;
    reset = 1'b0;
    #1;

    sweep_zero("post_reset");

    // Directed vector table.
    for (int i = 0; i < 15; i++) begin
      wr_en   = tbl[i].we;
      wr_addr = tbl[i].wa;
      wr_data = tbl[i].wd;
      sb_set  = tbl[i].ss;
      sb_addr = tbl[i].sa;
      rd_addr = {tbl[i].ra1, tbl[i].ra0};
      expect_push({32'h0, tbl[i].d0}, tbl[i].b0);
      expect_push({32'h0, tbl[i].d1}, tbl[i].b1);
      @(negedge clk);
      chk($sformatf("vec%0d.p0", i), {32'h0, rd_data[31:0]}, rd_busy[0]);
      chk($sformatf("vec%0d.p1", i), {32'h0, rd_data[63:32]}, rd_busy[1]);
      @(posedge clk);
      #1;
    end

    // Fill r1..r31 with their index; mark r3 pending on the last write.
    for (int a = 1; a < 32; a++) begin
      wr_en   = 1'b1;
      wr_addr = 5'(a);
      wr_data = 32'(a);
      sb_set  = (a == 31);
      sb_addr = 5'd3;
      @(posedge clk);
      #1;
    end
    idle_a();
    rd_addr = {5'd31, 5'd3};
    expect_push(64'd3, 1'b1);
    expect_push(64'd31, 1'b0);
    @(negedge clk);
    chk("filled.r3", {32'h0, rd_data[31:0]}, rd_busy[0]);
    chk("filled.r31", {32'h0, rd_data[63:32]}, rd_busy[1]);

    // Assert reset between edges: outputs must clear before the next edge.
    #1;
    reset   = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 5'd4;
    wr_data = 32'hFFFF_FFFF;
    sb_set  = 1'b1;
    sb_addr = 5'd4;
    rd_addr = {5'd4, 5'd3};
    expect_push(64'h0, 1'b0);
    expect_push(64'h0, 1'b0);
    #1;
    chk("async_rst.r3", {32'h0, rd_data[31:0]}, rd_busy[0]);
    chk("async_rst.r4", {32'h0, rd_data[63:32]}, rd_busy[1]);
    @(posedge clk);
    #1;
    expect_push(64'h0, 1'b0);
    expect_push(64'h0, 1'b0);
    chk("rst_edge.r3", {32'h0, rd_data[31:0]}, rd_busy[0]);
    chk("rst_edge.r4", {32'h0, rd_data[63:32]}, rd_busy[1]);
    idle_a();
    #1;
    reset = 1'b0;
    #1;
    sweep_zero("after_async_rst");

    // Randomised run on the wide build against the reference model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [3:0]  ra;
      logic [63:0] d;
      logic        b;
      logic        weff;
      logic        seff;
      b_wr_en   = 1'($urandom_range(0, 1));
      b_wr_addr = 4'($urandom_range(0, 15));
      b_wr_data = {$urandom, $urandom};
      b_sb_set  = ($urandom_range(0, 3) == 0);
      b_sb_addr = 4'($urandom_range(0, 15));
      for (int p = 0; p < 4; p++) begin
        if ($urandom_range(0, 3) == 0) begin
          b_rd_addr[p*4 +: 4] = b_wr_addr;
        end else begin
          b_rd_addr[p*4 +: 4] = 4'($urandom_range(0, 15));
        end
      end
      weff = b_wr_en && (b_wr_addr != 4'd0);
      seff = b_sb_set && (b_sb_addr != 4'd0);
      for (int p = 0; p < 4; p++) begin
        ra = b_rd_addr[p*4 +: 4];
        d  = m2[ra];
        b  = busy2[ra];
        if (weff && b_wr_addr == ra) begin
          d = b_wr_data;
          if (!(seff && b_sb_addr == ra)) b = 1'b0;
        end
        if (ra == 4'd0) begin
          d = '0;
          b = 1'b0;
        end
        expect_push(d, b);
      end
      @(negedge clk);
      for (int p = 0; p < 4; p++) begin
        chk($sformatf("rand%0d.p%0d", cyc, p), b_rd_data[p*64 +: 64], b_rd_busy[p]);
      end
      @(posedge clk);
      if (weff) begin
        m2[b_wr_addr]    = b_wr_data;
        busy2[b_wr_addr] = 1'b0;
      end
      if (seff) busy2[b_sb_addr] = 1'b1;
      #1;
    end

    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
